// File: rtl/prim_ram_2p_init.sv
// Single-clock true dual-port RAM: byte-masked writes, write-first cross-port forwarding,
// zeroing sweep after reset / init_req_i. Optional per-byte parity: PRIM_RAM_2P_INIT_PARITY_EN.
module prim_ram_2p_init #(
  parameter int Width     = 32,
  parameter int Depth     = 128,
  parameter int Aw        = $clog2(Depth),
  parameter bit OutputReg = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               init_req_i,
  output logic               init_busy_o,
  input  logic               a_req_i,
  output logic               a_gnt_o,
  input  logic               a_write_i,
  input  logic [Aw-1:0]      a_addr_i,
  input  logic [Width-1:0]   a_wdata_i,
  input  logic [Width/8-1:0] a_wmask_i,
  output logic               a_rvalid_o,
  output logic [Width-1:0]   a_rdata_o,
  output logic [Width/8-1:0] a_rerror_o,
  input  logic               b_req_i,
  output logic               b_gnt_o,
  input  logic               b_write_i,
  input  logic [Aw-1:0]      b_addr_i,
  input  logic [Width-1:0]   b_wdata_i,
  input  logic [Width/8-1:0] b_wmask_i,
  output logic               b_rvalid_o,
  output logic [Width-1:0]   b_rdata_o,
  output logic [Width/8-1:0] b_rerror_o
);
  localparam int Lanes  = Width / 8;
  localparam int Stages = OutputReg ? 2 : 1;

  typedef struct packed {
    logic             req;
    logic             write;
    logic [Aw-1:0]    addr;
    logic [Width-1:0] wdata;
    logic [Lanes-1:0] wmask;
  } port_req_t;

  typedef enum logic {SWEEP, READY} state_e;

  state_e                      state;
  logic [Aw-1:0]               sweep_cnt;
  logic                        gnt;
  port_req_t [1:0]             preq;
  logic [1:0]                  acc, in_rng, rvalid;
  logic [1:0][Lanes-1:0]       we, rerror;
  logic [1:0][Width-1:0]       rdata;
  logic                        same_addr;

  logic [Width-1:0] mem [Depth];
`ifdef PRIM_RAM_2P_INIT_PARITY_EN
  logic [Lanes-1:0] par_mem [Depth];
`endif

  assign preq[0] = '{req: a_req_i, write: a_write_i, addr: a_addr_i, wdata: a_wdata_i, wmask: a_wmask_i};
  assign preq[1] = '{req: b_req_i, write: b_write_i, addr: b_addr_i, wdata: b_wdata_i, wmask: b_wmask_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni || init_req_i) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
    end else if (state == SWEEP) begin
      if (sweep_cnt == Aw'(Depth - 1)) state <= READY;
      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  assign init_busy_o = (state == SWEEP);
  // Reset and init_req_i drop requests in the same cycle they are seen.
  assign gnt       = (state == READY) & rst_ni & ~init_req_i;
  assign a_gnt_o   = gnt;
  assign b_gnt_o   = gnt;
  assign acc       = {preq[1].req, preq[0].req} & {2{gnt}};
  assign same_addr = (preq[0].addr == preq[1].addr);

  // Port A owns every lane it writes on an address collision; B keeps the rest.
  always_comb begin
    we = '0;
    if (acc[0] && preq[0].write && in_rng[0]) we[0] = preq[0].wmask;
    if (acc[1] && preq[1].write && in_rng[1])
      we[1] = preq[1].wmask & ~(same_addr ? we[0] : {Lanes{1'b0}});
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && state == SWEEP) begin
      mem[sweep_cnt] <= '0;
`ifdef PRIM_RAM_2P_INIT_PARITY_EN
      par_mem[sweep_cnt] <= '0;
`endif
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int l = 0; l < Lanes; l++) begin
          if (we[p][l]) begin
            mem[preq[p].addr][8*l +: 8] <= preq[p].wdata[8*l +: 8];
`ifdef PRIM_RAM_2P_INIT_PARITY_EN
            par_mem[preq[p].addr][l] <= ^preq[p].wdata[8*l +: 8];
`endif
          end
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int Q = 1 - p;
    logic [Width-1:0] rd_data, d1, dout;
    logic [Lanes-1:0] rd_err, e1, eout;
    logic [Stages:0]  vld_pipe;
    logic [Stages:1]  vld_q;

    if (Depth < 2**Aw) begin : g_rng
      assign in_rng[p] = (preq[p].addr < Aw'(Depth));
    end else begin : g_full
      assign in_rng[p] = 1'b1;
    end

    // Write-first: lanes the other port writes this cycle come straight from its wdata.
    always_comb begin
      rd_data = '0;
      rd_err  = '0;
      if (in_rng[p]) begin
        for (int l = 0; l < Lanes; l++) begin
          if (same_addr && we[Q][l]) begin
            rd_data[8*l +: 8] = preq[Q].wdata[8*l +: 8];
          end else begin
            rd_data[8*l +: 8] = mem[preq[p].addr][8*l +: 8];
`ifdef PRIM_RAM_2P_INIT_PARITY_EN
            rd_err[l] = par_mem[preq[p].addr][l] ^ (^mem[preq[p].addr][8*l +: 8]);
`endif
          end
        end
      end
    end

    assign vld_pipe = {vld_q, acc[p] & ~preq[p].write};

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        vld_q <= '0;
        d1    <= '0;
        e1    <= '0;
      end else begin
        vld_q <= vld_pipe[Stages-1:0];
        if (vld_pipe[0]) begin
          d1 <= rd_data;
          e1 <= rd_err;
        end
      end
    end

    if (OutputReg) begin : g_oreg
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          dout <= '0;
          eout <= '0;
        end else if (vld_pipe[1]) begin
          dout <= d1;
          eout <= e1;
        end
      end
    end else begin : g_noreg
      assign dout = d1;
      assign eout = e1;
    end

    assign rvalid[p] = vld_pipe[Stages];
    assign rdata[p]  = dout;
    assign rerror[p] = eout;
  end

  assign a_rvalid_o = rvalid[0];
  assign a_rdata_o  = rdata[0];
  assign a_rerror_o = rerror[0];
  assign b_rvalid_o = rvalid[1];
  assign b_rdata_o  = rdata[1];
  assign b_rerror_o = rerror[1];

endmodule

// File: tb/tb_prim_ram_2p_init.sv
// Directed bench: Depth=128/OutputReg=0 main instance, Depth=100/OutputReg=1 range/latency instance.
module tb_prim_ram_2p_init;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, init_req;
  logic        busy, a_gnt, b_gnt, a_req, b_req, a_write, b_write, a_rvalid, b_rvalid;
  logic [6:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [3:0]  a_wmask, b_wmask, a_rerror, b_rerror;

  logic        e_init_req, e_busy, e_gnt, e_req, e_write, e_rvalid;
  logic        e_bgnt, e_breq, e_bwrite, e_brvalid;
  logic [6:0]  e_addr, e_baddr;
  logic [31:0] e_wdata, e_rdata, e_bwdata, e_brdata;
  logic [3:0]  e_wmask, e_rerror, e_bwmask, e_brerror;

  int vectors, errs, n, n2, ng;

  prim_ram_2p_init dut (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .init_busy_o(busy),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_write_i(a_write), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_wmask_i(a_wmask), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .a_rerror_o(a_rerror),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_write_i(b_write), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_wmask_i(b_wmask), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .b_rerror_o(b_rerror)
  );

  prim_ram_2p_init #(.Depth(100), .OutputReg(1'b1)) dut100 (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(e_init_req), .init_busy_o(e_busy),
    .a_req_i(e_req), .a_gnt_o(e_gnt), .a_write_i(e_write), .a_addr_i(e_addr),
    .a_wdata_i(e_wdata), .a_wmask_i(e_wmask), .a_rvalid_o(e_rvalid), .a_rdata_o(e_rdata),
    .a_rerror_o(e_rerror),
    .b_req_i(e_breq), .b_gnt_o(e_bgnt), .b_write_i(e_bwrite), .b_addr_i(e_baddr),
    .b_wdata_i(e_bwdata), .b_wmask_i(e_bwmask), .b_rvalid_o(e_brvalid), .b_rdata_o(e_brdata),
    .b_rerror_o(e_brerror)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a_req = 0; b_req = 0; e_req = 0;
  endtask

  task automatic a_rd(input logic [6:0] ad);
    a_req = 1; a_write = 0; a_addr = ad;
  endtask
  task automatic b_rd(input logic [6:0] ad);
    b_req = 1; b_write = 0; b_addr = ad;
  endtask
  task automatic e_rd(input logic [6:0] ad);
    e_req = 1; e_write = 0; e_addr = ad;
  endtask
  task automatic a_wr(input logic [6:0] ad, input logic [31:0] d, input logic [3:0] m);
    a_req = 1; a_write = 1; a_addr = ad; a_wdata = d; a_wmask = m;
  endtask
  task automatic b_wr(input logic [6:0] ad, input logic [31:0] d, input logic [3:0] m);
    b_req = 1; b_write = 1; b_addr = ad; b_wdata = d; b_wmask = m;
  endtask
  task automatic e_wr(input logic [6:0] ad, input logic [31:0] d, input logic [3:0] m);
    e_req = 1; e_write = 1; e_addr = ad; e_wdata = d; e_wmask = m;
  endtask

  initial begin
    vectors = 0; errs = 0;
    rst_n = 0; init_req = 0; e_init_req = 0;
    a_req = 0; a_write = 0; a_addr = '0; a_wdata = '0; a_wmask = '0;
    b_req = 0; b_write = 0; b_addr = '0; b_wdata = '0; b_wmask = '0;
    e_req = 0; e_write = 0; e_addr = '0; e_wdata = '0; e_wmask = '0;
    e_breq = 0; e_bwrite = 0; e_baddr = '0; e_bwdata = '0; e_bwmask = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_gnt", a_gnt, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_rerror", a_rerror, 0);

    rst_n = 1;
    n = 0; n2 = 0;
    while (busy && n < 400) begin
      if (e_busy) n2++;
      tick(); n++;
    end
    chk("sweep_len", n, 128);
    chk("sweep_len_d100", n2, 100);
    chk("gnt_ready", a_gnt, 1);

    for (int i = 0; i < 128; i++) begin
      a_rd(7'(i)); tick();
      chk("zero_rvalid", a_rvalid, 1);
      chk("zero_rdata", a_rdata, 0);
    end
    idle();

    a_wr(5, 32'h11223344, 4'hf); tick();
    chk("wr_no_rvalid", a_rvalid, 0);
    a_wr(5, 32'hDEADBEEF, 4'b0101); tick();
    idle(); b_rd(5); tick();
    chk("mask_rvalid", b_rvalid, 1);
    chk("mask_rdata", b_rdata, 32'h11AD33EF);

    idle(); a_wr(9, 32'hAAAAAAAA, 4'b0011); b_wr(9, 32'hBBBBBBBB, 4'b1111); tick();
    idle(); a_rd(9); tick();
    chk("ww_collide", a_rdata, 32'hBBBBAAAA);

    idle(); a_rd(3); b_wr(3, 32'h12345678, 4'b1100); tick();
    chk("wf_rvalid", a_rvalid, 1);
    chk("wf_rdata", a_rdata, 32'h12340000);
    chk("wf_b_no_rvalid", b_rvalid, 0);

    idle(); a_rd(5); b_rd(5); tick();
    chk("rr_a", a_rdata, 32'h11AD33EF);
    chk("rr_b", b_rdata, 32'h11AD33EF);

    idle(); tick();
    chk("hold_rvalid", a_rvalid, 0);
    chk("hold_rdata", a_rdata, 32'h11AD33EF);

    a_rd(9); tick();
    chk("pipe0", a_rdata, 32'hBBBBAAAA);
    a_rd(3); tick();
    chk("pipe1_v", a_rvalid, 1);
    chk("pipe1", a_rdata, 32'h12340000);
    idle();

`ifdef PRIM_RAM_2P_INIT_PARITY_EN
    dut.par_mem[7][2] = ~dut.par_mem[7][2];
    a_rd(7); tick();
    chk("par_err", a_rerror, 4'b0100);
    chk("par_rdata", a_rdata, 0);
`else
    a_rd(7); tick();
    chk("par_tied", a_rerror, 0);
    chk("par_rdata", a_rdata, 0);
`endif
    idle();

    e_wr(99, 32'h01020304, 4'hf); tick();
    e_wr(120, 32'h55555555, 4'hf); tick();
    e_rd(99); tick();
    chk("d100_lat1", e_rvalid, 0);
    e_rd(120); tick();
    chk("d100_lat2_v", e_rvalid, 1);
    chk("d100_lat2_d", e_rdata, 32'h01020304);
    idle(); tick();
    chk("d100_oor_v", e_rvalid, 1);
    chk("d100_oor_d", e_rdata, 0);
    chk("d100_oor_e", e_rerror, 0);
    tick();
    chk("d100_pulse", e_rvalid, 0);

    a_rd(5); tick();
    idle(); init_req = 1; b_wr(20, 32'hFFFFFFFF, 4'hf); #1;
    chk("init_gnt", b_gnt, 0);
    chk("inflight_v", a_rvalid, 1);
    chk("inflight_d", a_rdata, 32'h11AD33EF);
    tick(); init_req = 0; idle();
    chk("init_busy", busy, 1);
    repeat (40) tick();
    chk("sweep_mid", busy, 1);

    rst_n = 0; tick(); rst_n = 1;
    n = 0; ng = 0;
    while (busy && n < 400) begin
      if (a_gnt || b_gnt) ng++;
      tick(); n++;
    end
    chk("resweep_len", n, 128);
    chk("resweep_gnt", ng, 0);
    for (int i = 0; i < 128; i++) begin
      a_rd(7'(i)); tick();
      chk("rezero", a_rdata, 0);
    end
    idle();

    a_wr(9, 32'h0F0F0F0F, 4'hf); tick();
    a_rd(9); e_rd(99); tick();
    chk("pre_rst_d", a_rdata, 32'h0F0F0F0F);
    idle(); rst_n = 0; tick();
    chk("rst_cancel_v", e_rvalid, 0);
    chk("rst_rdata2", a_rdata, 0);
    chk("rst_busy2", busy, 1);
    rst_n = 1; tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
